// File: rtl/lane_mover_pkg.sv
`default_nettype none
// ============================================================================
//  Module : lane_mover_pkg
//  Brief  : Shared coordinate constants, lane config types and reset helper.
//  Rev    : 1.0
// ============================================================================
package lane_mover_pkg;

   localparam int X_W   = 11;
   localparam int X_MIN = -48;
   localparam int X_MAX = 687;
   localparam int SPAN  = X_MAX - X_MIN + 1;

   typedef logic signed [X_W-1:0] pos_t;

   typedef struct packed {
      logic       dir;
      logic [3:0] period;
      logic [2:0] step;
   } lane_cfg_t;

   typedef enum logic {
      DIR_RIGHT = 1'b0,
      DIR_LEFT  = 1'b1
   } dir_e;

   function automatic pos_t reset_pos(input int lane, input int obj,
                                      input int spacing, input int stagger);
      return pos_t'(X_MIN + obj * spacing + lane * stagger);
   endfunction

endpackage
`default_nettype wire

// File: rtl/lane_mover_lane.sv
`default_nettype none
// ============================================================================
//  Module : lane_mover_lane
//  Brief  : One scrolling lane: config register, frame divider and wrapping
//           object position registers.
//  Rev    : 1.0
// ============================================================================
module lane_mover_lane
   import lane_mover_pkg::*;
#(
   parameter int LANE_IDX      = 0,
   parameter int OBJS_PER_LANE = 3,
   parameter int SPACING       = 224,
   parameter int STAGGER       = 48
) (
   input  logic                         frame_clk,
   input  logic                         Reset,
   input  logic                         run,
   input  logic                         cfg_we,
   input  logic                         cfg_dir,
   input  logic [3:0]                   cfg_period,
   input  logic [2:0]                   cfg_step,
   output logic [OBJS_PER_LANE*X_W-1:0] obj_x,
   output logic                         lane_dir,
   output pos_t                         lane_step
);

   localparam logic      c_reset_dir = ((LANE_IDX % 2) == 1);
   localparam lane_cfg_t c_cfg_reset = '{dir: c_reset_dir, period: 4'd0, step: 3'd1};

   // Wrap arithmetic is one bit wider than a position so x +/- step never overflows.
   localparam logic signed [X_W:0] c_min_w  = (X_W+1)'(X_MIN);
   localparam logic signed [X_W:0] c_max_w  = (X_W+1)'(X_MAX);
   localparam logic signed [X_W:0] c_span_w = (X_W+1)'(SPAN);

   lane_cfg_t              r_cfg;
   logic [3:0]             r_cnt;
   pos_t                   r_lane_step;

   logic                   w_tick;
   logic                   w_move;
   logic signed [X_W:0]    w_step_ext;
   pos_t                   w_step_p;
   pos_t                   w_disp;

   assign w_tick     = (r_cnt == r_cfg.period);
   assign w_move     = run & ~cfg_we & w_tick;
   assign w_step_ext = {{(X_W-2){1'b0}}, r_cfg.step};
   assign w_step_p   = {{(X_W-3){1'b0}}, r_cfg.step};
   assign w_disp     = (r_cfg.dir == DIR_LEFT) ? -w_step_p : w_step_p;

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         r_cfg       <= c_cfg_reset;
         r_cnt       <= 4'd0;
         r_lane_step <= '0;
      end else if (cfg_we) begin
         // A write always wins over a step due on the same edge.
         r_cfg       <= '{dir: cfg_dir, period: cfg_period, step: cfg_step};
         r_cnt       <= 4'd0;
         r_lane_step <= '0;
      end else if (run) begin
         r_cnt       <= w_tick ? 4'd0 : r_cnt + 4'd1;
         r_lane_step <= w_tick ? w_disp : '0;
      end else begin
         r_lane_step <= '0;
      end
   end

   generate
      for (genvar k = 0; k < OBJS_PER_LANE; k++) begin : g_obj
         localparam pos_t c_x_reset = reset_pos(LANE_IDX, k, SPACING, STAGGER);

         pos_t                r_x;
         logic signed [X_W:0] w_up;
         logic signed [X_W:0] w_dn;
         logic signed [X_W:0] w_next_wide;

         assign w_up = {r_x[X_W-1], r_x} + w_step_ext;
         assign w_dn = {r_x[X_W-1], r_x} - w_step_ext;

         always_comb begin
            w_next_wide = w_up;
            if (r_cfg.dir == DIR_LEFT) begin
               w_next_wide = (w_dn < c_min_w) ? w_dn + c_span_w : w_dn;
            end else begin
               w_next_wide = (w_up > c_max_w) ? w_up - c_span_w : w_up;
            end
         end

         always_ff @(posedge frame_clk or posedge Reset) begin
            if (Reset) begin
               r_x <= c_x_reset;
            end else if (w_move) begin
               r_x <= w_next_wide[X_W-1:0];
            end
         end

         assign obj_x[k*X_W +: X_W] = r_x;
      end
   endgenerate

   assign lane_dir  = r_cfg.dir;
   assign lane_step = r_lane_step;

endmodule
`default_nettype wire

// File: rtl/lane_mover.sv
`default_nettype none
// ============================================================================
//  Module : lane_mover
//  Brief  : Multi-lane horizontal scroller for river/road rows with
//           runtime-writable per-lane direction, step and frame divider.
//  Rev    : 1.0
// ============================================================================
module lane_mover
   import lane_mover_pkg::*;
#(
   parameter int NUM_LANES     = 3,
   parameter int OBJS_PER_LANE = 3,
   parameter int SPACING       = 224,
   parameter int STAGGER       = 48,
   parameter int LANE_W        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                                   frame_clk,
   input  logic                                   Reset,
   input  logic                                   run,
   input  logic                                   cfg_we,
   input  logic [LANE_W-1:0]                      cfg_lane,
   input  logic                                   cfg_dir,
   input  logic [3:0]                             cfg_period,
   input  logic [2:0]                             cfg_step,
   output logic [NUM_LANES*OBJS_PER_LANE*X_W-1:0] obj_x,
   output logic [NUM_LANES-1:0]                   lane_dir,
   output logic [NUM_LANES*X_W-1:0]               lane_step
);

   localparam int c_lane_bits = OBJS_PER_LANE * X_W;

   generate
      for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
         // Out-of-range lane indices match no instance and are dropped here.
         logic w_lane_we;
         pos_t w_lane_step;

         assign w_lane_we = cfg_we && (cfg_lane == LANE_W'(l));

         lane_mover_lane #(
            .LANE_IDX      (l),
            .OBJS_PER_LANE (OBJS_PER_LANE),
            .SPACING       (SPACING),
            .STAGGER       (STAGGER)
         ) u_lane (
            .frame_clk  (frame_clk),
            .Reset      (Reset),
            .run        (run),
            .cfg_we     (w_lane_we),
            .cfg_dir    (cfg_dir),
            .cfg_period (cfg_period),
            .cfg_step   (cfg_step),
            .obj_x      (obj_x[l*c_lane_bits +: c_lane_bits]),
            .lane_dir   (lane_dir[l]),
            .lane_step  (w_lane_step)
         );

         assign lane_step[l*X_W +: X_W] = w_lane_step;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_lane_mover.sv
`default_nettype none
// ============================================================================
//  Module : tb_lane_mover
//  Brief  : Self-checking bench for lane_mover against a modular-arithmetic
//           reference model with directed and randomized stimulus.
//  Rev    : 1.0
// ============================================================================
module tb_lane_mover;

   localparam int NL = 3;
   localparam int NO = 3;
   localparam int XW = 11;
   localparam int XMIN = -48;
   localparam int XMAX = 687;
   localparam int SPANV = XMAX - XMIN + 1;

   logic                 frame_clk;
   logic                 Reset;
   logic                 run;
   logic                 cfg_we;
   logic [1:0]           cfg_lane;
   logic                 cfg_dir;
   logic [3:0]           cfg_period;
   logic [2:0]           cfg_step;
   logic [NL*NO*XW-1:0]  obj_x;
   logic [NL-1:0]        lane_dir;
   logic [NL*XW-1:0]     lane_step;

   int n_checks = 0;
   int n_err    = 0;

   int mx  [NL][NO];
   int mdir[NL];
   int mper[NL];
   int mstp[NL];
   int mcnt[NL];
   int mls [NL];

   lane_mover dut (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .run        (run),
      .cfg_we     (cfg_we),
      .cfg_lane   (cfg_lane),
      .cfg_dir    (cfg_dir),
      .cfg_period (cfg_period),
      .cfg_step   (cfg_step),
      .obj_x      (obj_x),
      .lane_dir   (lane_dir),
      .lane_step  (lane_step)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int dut_x(input int l, input int k);
      logic signed [XW-1:0] v;
      v = obj_x[(l*NO+k)*XW +: XW];
      return int'(v);
   endfunction

   function automatic int dut_ls(input int l);
      logic signed [XW-1:0] v;
      v = lane_step[l*XW +: XW];
      return int'(v);
   endfunction

   function automatic int wrapx(input int v);
      return XMIN + (((v - XMIN) % SPANV) + SPANV) % SPANV;
   endfunction

   function automatic void model_reset();
      for (int l = 0; l < NL; l++) begin
         for (int k = 0; k < NO; k++) mx[l][k] = XMIN + k*224 + l*48;
         mdir[l] = l % 2;
         mper[l] = 0;
         mstp[l] = 1;
         mcnt[l] = 0;
         mls[l]  = 0;
      end
   endfunction

   function automatic void model_edge();
      for (int l = 0; l < NL; l++) begin
         if (cfg_we && int'(cfg_lane) == l) begin
            mdir[l] = int'(cfg_dir);
            mper[l] = int'(cfg_period);
            mstp[l] = int'(cfg_step);
            mcnt[l] = 0;
            mls[l]  = 0;
         end else if (!run) begin
            mls[l] = 0;
         end else if (mcnt[l] == mper[l]) begin
            int d;
            d = (mdir[l] != 0) ? -mstp[l] : mstp[l];
            mcnt[l] = 0;
            mls[l]  = d;
            for (int k = 0; k < NO; k++) mx[l][k] = wrapx(mx[l][k] + d);
         end else begin
            mcnt[l] = mcnt[l] + 1;
            mls[l]  = 0;
         end
      end
   endfunction

   task automatic check_all(input string tag);
      for (int l = 0; l < NL; l++) begin
         for (int k = 0; k < NO; k++) check({tag, "_x"}, dut_x(l, k), mx[l][k]);
         check({tag, "_dir"}, int'(lane_dir[l]), mdir[l]);
         check({tag, "_ls"}, dut_ls(l), mls[l]);
      end
   endtask

   task automatic tick();
      @(posedge frame_clk);
      model_edge();
      #1;
      cfg_we = 1'b0;
   endtask

   task automatic write_cfg(input int lane, input int d, input int p, input int s);
      cfg_we     = 1'b1;
      cfg_lane   = 2'(lane);
      cfg_dir    = 1'(d);
      cfg_period = 4'(p);
      cfg_step   = 3'(s);
      tick();
   endtask

   initial begin
      int guard;
      int tgt;
      int snap[NL][NO];
      int sdir[NL];
      int x_before;

      Reset = 1'b0; run = 1'b0; cfg_we = 1'b0; cfg_lane = '0;
      cfg_dir = 1'b0; cfg_period = '0; cfg_step = '0;
      #1 Reset = 1'b1;
      model_reset();
      #1 check_all("rst_async");
      repeat (2) @(posedge frame_clk);
      #1 check_all("rst_hold");
      check("rst_l0o1", dut_x(0, 1), 176);
      check("rst_l2o2", dut_x(2, 2), 496);
      check("rst_dirs", int'(lane_dir), 2);
      @(negedge frame_clk) Reset = 1'b0;

      // Basic motion
      run = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_all("basic");
         check("basic_ls0", dut_ls(0), 1);
         check("basic_ls1", dut_ls(1), -1);
      end
      check("basic_l0o0", dut_x(0, 0), -43);
      check("basic_l0o2", dut_x(0, 2), 405);
      check("basic_l1o0", dut_x(1, 0), -5);

      // Right wrap on lane0
      write_cfg(0, 0, 0, 1);
      check_all("rw_wr");
      guard = 0;
      tgt = -1;
      while (tgt < 0 && guard < 800) begin
         for (int k = 0; k < NO; k++) if (mx[0][k] == XMAX) tgt = k;
         if (tgt < 0) begin
            tick();
            check_all("rw_run");
            guard++;
         end
      end
      if (tgt < 0) check("rw_timeout", 0, 1);
      else begin
         tick();
         check("rwrap", dut_x(0, tgt), -48);
      end

      // Left wrap on lane1 with step 2
      write_cfg(1, 1, 0, 1);
      if (((mx[1][0] - XMIN) % 2) != 0) begin
         tick();
         check_all("lw_align");
      end
      write_cfg(1, 1, 0, 2);
      guard = 0;
      tgt = -1;
      while (tgt < 0 && guard < 800) begin
         for (int k = 0; k < NO; k++) if (mx[1][k] == XMIN) tgt = k;
         if (tgt < 0) begin
            tick();
            check_all("lw_run");
            guard++;
         end
      end
      if (tgt < 0) check("lw_timeout", 0, 1);
      else begin
         tick();
         check("lwrap", dut_x(1, tgt), 686);
      end

      // Divider on lane2
      write_cfg(2, 0, 2, 3);
      check_all("div_wr");
      for (int i = 1; i <= 11; i++) begin
         tick();
         check_all("div");
         check("div_ls", dut_ls(2), (i % 3 == 0) ? 3 : 0);
      end
      // Collision: write lands on a step edge
      x_before = mx[2][0];
      write_cfg(2, 0, 2, 3);
      check("coll_ls", dut_ls(2), 0);
      check("coll_x", dut_x(2, 0), x_before);
      for (int i = 1; i <= 3; i++) begin
         tick();
         check_all("coll");
         check("coll_ls_after", dut_ls(2), (i == 3) ? 3 : 0);
      end

      // Freeze with writes, including an out-of-range lane
      tick();
      for (int l = 0; l < NL; l++) begin
         sdir[l] = mdir[l];
         for (int k = 0; k < NO; k++) snap[l][k] = mx[l][k];
      end
      run = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) write_cfg(0, 1, 0, 2);
         else if (i == 5) write_cfg(3, 0, 5, 7);
         else tick();
         check_all("frz");
         for (int l = 0; l < NL; l++) begin
            check("frz_ls", dut_ls(l), 0);
            for (int k = 0; k < NO; k++) check("frz_x", dut_x(l, k), snap[l][k]);
         end
      end
      check("frz_dir0", int'(lane_dir[0]), 1);
      check("frz_dir1", int'(lane_dir[1]), sdir[1]);
      check("frz_dir2", int'(lane_dir[2]), sdir[2]);
      run = 1'b1;
      tick();
      check_all("frz_resume");
      check("frz_cfg0", dut_ls(0), -2);

      // Randomized run
      for (int i = 0; i < 300; i++) begin
         run = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 99) < 15) begin
            cfg_we     = 1'b1;
            cfg_lane   = 2'($urandom_range(0, 3));
            cfg_dir    = 1'($urandom_range(0, 1));
            cfg_period = 4'($urandom_range(0, 15));
            cfg_step   = 3'($urandom_range(0, 7));
         end
         tick();
         check_all("rnd");
      end

      // Custom config then asynchronous reset mid-frame
      run = 1'b1;
      write_cfg(0, 1, 3, 5);
      write_cfg(1, 0, 7, 6);
      write_cfg(2, 1, 1, 4);
      for (int i = 0; i < 100; i++) begin
         tick();
         check_all("pre_rst");
      end
      #2 Reset = 1'b1;
      model_reset();
      #1 check_all("midrst");
      check("midrst_l1o0", dut_x(1, 0), 0);
      check("midrst_dirs", int'(lane_dir), 2);
      @(negedge frame_clk) Reset = 1'b0;
      tick();
      check_all("post_rst");
      check("post_rst_l0o0", dut_x(0, 0), -47);
      check("post_rst_l1o0", dut_x(1, 0), -1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
